// File: rtl/modulo_contador_garrafas_pkg.sv
// Shared definitions for the bottle counter and its sensor front end.
// Holds the FSM state encoding, the BCD digit limit, the default batch size
// and a helper that extracts one decimal digit from an integer constant.
package modulo_contador_garrafas_pkg;

    typedef enum logic [1:0] {
        Parado   = 2'd0,
        Contando = 2'd1,
        Cheio    = 2'd2
    } estado_t;

    localparam int unsigned BCD_MAX     = 9;
    localparam int unsigned LOTE_PADRAO = 12;

    // Decimal digit of 'valor' at weight 'casa' (1 for units, 10 for tens).
    function automatic logic [3:0] digito(input int unsigned valor, input int unsigned casa);
        return 4'((valor / casa) % 10);
    endfunction

endpackage

// File: rtl/modulo_sincroniza_borda.sv
// Synchroniser plus rising-edge detector for a slow asynchronous sensor.
// Ports:
//   clk    - system clock
//   rst_n  - synchronous active-low reset, clears every flop
//   sensor - raw asynchronous input
//   borda  - high for one cycle after the synchronised input rises
module modulo_sincroniza_borda #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    output logic borda
);

    if (SYNC_STAGES < 2) begin : g_check_stages
        $error("SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sensor};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign borda = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/modulo_contador_garrafas.sv
// BCD bottle counter for the filling line.
// Counts synchronised sensor rising edges as units/tens digits while the line
// runs and freezes the count once a full batch of LOTE bottles is reached.
// Ports:
//   clk, rst_n     - clock and synchronous active-low reset
//   sensor         - raw bottle-presence sensor (asynchronous)
//   en             - line running; counting suspended when low
//   clr            - operator clear of the count
//   ack            - operator acknowledge of a completed batch
//   unidade/dezena - registered BCD digits of the count
//   pulso_garrafa  - one-cycle strobe per accepted bottle
//   lote_completo  - high while the batch is complete
module modulo_contador_garrafas
    import modulo_contador_garrafas_pkg::*;
#(
    parameter int unsigned LOTE        = LOTE_PADRAO,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor,
    input  logic       en,
    input  logic       clr,
    input  logic       ack,
    output logic [3:0] unidade,
    output logic [3:0] dezena,
    output logic       pulso_garrafa,
    output logic       lote_completo
);

    if (LOTE < 1 || LOTE > 99) begin : g_check_lote
        $error("LOTE must be in the range 1..99");
    end

    localparam logic [3:0] LOTE_UNI = digito(LOTE, 1);
    localparam logic [3:0] LOTE_DEZ = digito(LOTE, 10);

    estado_t    estado_q, estado_d;
    logic [3:0] unidade_q, unidade_d;
    logic [3:0] dezena_q, dezena_d;
    logic       pulso_q, pulso_d;
    logic [3:0] uni_inc, dez_inc;
    logic       borda;

    modulo_sincroniza_borda #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sincroniza_borda (
        .clk    (clk),
        .rst_n  (rst_n),
        .sensor (sensor),
        .borda  (borda)
    );

    // BCD decade increment; 99 is never incremented since LOTE <= 99.
    always_comb begin
        uni_inc = unidade_q + 4'd1;
        dez_inc = dezena_q;
        if (unidade_q == 4'(BCD_MAX)) begin
            uni_inc = 4'd0;
            dez_inc = dezena_q + 4'd1;
        end
    end

    always_comb begin
        estado_d  = estado_q;
        unidade_d = unidade_q;
        dezena_d  = dezena_q;
        pulso_d   = 1'b0;

        if (clr) begin
            // Clear wins over any coincident edge or acknowledge.
            unidade_d = 4'd0;
            dezena_d  = 4'd0;
            estado_d  = en ? Contando : Parado;
        end else begin
            unique case (estado_q)
                Parado: begin
                    if (en) estado_d = Contando;
                end
                Contando: begin
                    if (!en) begin
                        estado_d = Parado;
                    end else if (borda) begin
                        unidade_d = uni_inc;
                        dezena_d  = dez_inc;
                        pulso_d   = 1'b1;
                        if (uni_inc == LOTE_UNI && dez_inc == LOTE_DEZ) estado_d = Cheio;
                    end
                end
                Cheio: begin
                    if (ack) begin
                        unidade_d = 4'd0;
                        dezena_d  = 4'd0;
                        estado_d  = en ? Contando : Parado;
                    end
                end
                default: estado_d = Parado;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            estado_q  <= Parado;
            unidade_q <= 4'd0;
            dezena_q  <= 4'd0;
            pulso_q   <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            unidade_q <= unidade_d;
            dezena_q  <= dezena_d;
            pulso_q   <= pulso_d;
        end
    end

    assign unidade       = unidade_q;
    assign dezena        = dezena_q;
    assign pulso_garrafa = pulso_q;
    assign lote_completo = (estado_q == Cheio);

endmodule

// File: tb/tb_modulo_contador_garrafas.sv
module tb_modulo_contador_garrafas;

    localparam int LOTE = 12;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sensor = 1'b0;
    logic       en = 1'b0;
    logic       clr = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] unidade;
    logic [3:0] dezena;
    logic       pulso_garrafa;
    logic       lote_completo;

    int checks = 0;
    int errors = 0;
    int strobes = 0;

    // Reference model: bottle count as an integer, past sensor samples in a
    // small delay line (an accepted edge is a 0->1 transition two samples back).
    int m_cnt = 0;
    bit m_full = 0;
    bit m_run = 0;
    bit m_pulse = 0;
    bit m_hist[3] = '{0, 0, 0};

    modulo_contador_garrafas #(
        .LOTE        (LOTE),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sensor        (sensor),
        .en            (en),
        .clr           (clr),
        .ack           (ack),
        .unidade       (unidade),
        .dezena        (dezena),
        .pulso_garrafa (pulso_garrafa),
        .lote_completo (lote_completo)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        bit bottle_edge;
        bottle_edge = m_hist[1] && !m_hist[2];
        m_pulse = 0;
        if (!rst_n) begin
            m_cnt = 0; m_full = 0; m_run = 0;
            m_hist = '{0, 0, 0};
        end else begin
            m_hist[2] = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = sensor;
            if (clr) begin
                m_cnt = 0; m_full = 0; m_run = en;
            end else if (m_full) begin
                if (ack) begin
                    m_cnt = 0; m_full = 0; m_run = en;
                end
            end else if (!m_run) begin
                m_run = en;
            end else if (!en) begin
                m_run = 0;
            end else if (bottle_edge) begin
                m_cnt++;
                m_pulse = 1;
                if (m_cnt == LOTE) m_full = 1;
            end
        end
    endtask

    task automatic step(input logic r, input logic s, input logic e, input logic c,
                        input logic a);
        rst_n = r; sensor = s; en = e; clr = c; ack = a;
        @(posedge clk);
        model_update();
        #1;
        if (pulso_garrafa) strobes++;
    endtask

    task automatic check(input string name, input int eu, input int ed, input bit ep,
                         input bit el);
        checks++;
        if (unidade !== 4'(eu) || dezena !== 4'(ed) || pulso_garrafa !== ep ||
            lote_completo !== el) begin
            errors++;
            $display("FAIL %s: got u=%0d d=%0d p=%0b l=%0b, want u=%0d d=%0d p=%0b l=%0b",
                     name, unidade, dezena, pulso_garrafa, lote_completo, eu, ed, ep, el);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_cnt % 10, m_cnt / 10, m_pulse, m_full);
    endtask

    // One isolated bottle: 4 cycles high, 4 low, checked every cycle.
    task automatic pulse(input logic e);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, (i < 4), e, 1'b0, 1'b0);
            check_model("pulse");
        end
    endtask

    typedef struct {
        logic r, s, e, c, a;
        int   eu, ed;
        bit   ep, el;
    } vec_t;

    vec_t vecs[15];

    initial begin
        int s0;
        bit rs, rc, ra, re, rsen;

        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[3]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        vecs[4]  = '{1, 1, 1, 0, 0, 1, 0, 1, 0};
        vecs[5]  = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
        vecs[6]  = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
        vecs[9]  = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
        vecs[10] = '{1, 1, 1, 0, 0, 1, 0, 0, 0};
        vecs[11] = '{1, 0, 1, 0, 0, 1, 0, 0, 0};
        vecs[12] = '{1, 0, 1, 0, 0, 2, 0, 1, 0};
        vecs[13] = '{1, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 15; i++) begin
            step(vecs[i].r, vecs[i].s, vecs[i].e, vecs[i].c, vecs[i].a);
            check($sformatf("vec%0d", i), vecs[i].eu, vecs[i].ed, vecs[i].ep, vecs[i].el);
        end

        // Three isolated pulses from reset.
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset", 0, 0, 0, 0);
        strobes = 0;
        for (int i = 0; i < 3; i++) pulse(1'b1);
        check("three_pulses", 3, 0, 0, 0);
        checks++;
        if (strobes != 3) begin
            errors++;
            $display("FAIL strobe_count: got %0d want 3", strobes);
        end

        // Fill the batch: 9 more pulses reach 12.
        for (int i = 3; i < 12; i++) begin
            pulse(1'b1);
            if (i == 9) check("after_10", 0, 1, 0, 0);
        end
        check("batch_full", 2, 1, 0, 1);
        strobes = 0;
        pulse(1'b1);
        check("pulse13_frozen", 2, 1, 0, 1);
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL cheio_strobe: got %0d want 0", strobes);
        end

        // ack on the same edge that would count a bottle.
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        check("ack_with_edge", 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        pulse(1'b1);
        check("after_ack", 1, 0, 0, 0);

        // Sensor held high for 50 cycles counts once.
        for (int i = 0; i < 50; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
            check_model("held_high");
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("held_high_once", 2, 0, 0, 0);

        // Suspended line ignores bottles.
        pulse(1'b0);
        pulse(1'b0);
        check("en_low", 2, 0, 0, 0);
        pulse(1'b1);
        check("en_back", 3, 0, 0, 0);

        // Reach 07, then clr on the counting edge.
        for (int i = 0; i < 4; i++) pulse(1'b1);
        check("at_07", 7, 0, 0, 0);
        strobes = 0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check("clr_with_edge", 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (strobes != 0) begin
            errors++;
            $display("FAIL clr_strobe: got %0d want 0", strobes);
        end

        // Reset mid-count, then a bottle with the line stopped.
        for (int i = 0; i < 3; i++) pulse(1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mid_reset", 0, 0, 0, 0);
        pulse(1'b0);
        check("after_reset_en0", 0, 0, 0, 0);

        // Randomised run against the model.
        s0 = 0;
        for (int i = 0; i < 3000; i++) begin
            rs   = ($urandom_range(0, 199) != 0);
            re   = ($urandom_range(0, 19) != 0);
            rc   = ($urandom_range(0, 99) == 0);
            ra   = ($urandom_range(0, 9) == 0);
            rsen = sensor;
            if ($urandom_range(0, 2) == 0) rsen = ~sensor;
            step(rs, rsen, re, rc, ra);
            check_model("random");
            if (lote_completo) s0++;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/modulo_contador_garrafas.md
Name: modulo_contador_garrafas

Overview:
Synchronous BCD bottle counter for the filling line. It takes the raw bottle-presence sensor, synchronises it and detects its rising edge. It counts bottles as units/tens decades and flags batch completion at a parameterised lot size. Its unidade/dezena outputs are the 4-bit count values consumed directly by the downstream unit and tens digit encoder stages.

Parameters:
LOTE, 12, bottles per batch; legal range 1..99; a value outside that range is an elaboration error.
SYNC_STAGES, 2, synchroniser flops on sensor; minimum 2.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
sensor  input  1  raw bottle sensor, asynchronous to clk, high while bottle present
en  input  1  line running; when 0, counting is suspended
clr  input  1  operator clear of the count, synchronous
ack  input  1  operator acknowledge of a completed batch
unidade  output  4  units digit, BCD 0..9
dezena  output  4  tens digit, BCD 0..9
pulso_garrafa  output  1  one-cycle strobe for each bottle accepted into the count
lote_completo  output  1  high while in state CHEIO

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - unidade=0, dezena=0, pulso_garrafa=0, lote_completo=0.
  - Synchroniser and edge flops all 0; state = PARADO.
- Sensor path:
  - SYNC_STAGES-flop synchroniser followed by one history flop.
  - edge = sync_out & ~history.
  - With SYNC_STAGES=2: sensor first sampled high at edge k gives edge=1 during cycle k+1..k+2.
  - The count and pulso_garrafa update at edge k+2.
  - Sensor held high produces exactly one edge; each new edge needs sensor low for at least one sampled cycle first.
- FSM states: PARADO, CONTANDO, CHEIO.
  - PARADO: edges ignored. en=1 -> CONTANDO.
  - CONTANDO: en=0 -> PARADO. On edge: increment count, assert pulso_garrafa for 1 cycle.
    - If the incremented value equals LOTE -> CHEIO in the same edge, so lote_completo rises together with the final count.
  - CHEIO: count frozen at LOTE; edges ignored (no pulso_garrafa); en ignored.
    - ack=1 -> count 00, state CONTANDO if en=1, else PARADO.
- Increment arithmetic:
  - unidade<9: unidade+1.
  - unidade=9: unidade=0, dezena+1.
  - dezena=9 & unidade=9 cannot increment, because LOTE<=99 forces CHEIO first.
- clr:
  - Highest priority after reset, in any state.
  - Count -> 00, pulso_garrafa=0, state -> CONTANDO if en=1 else PARADO.
  - A coincident edge is dropped. The synchroniser and history flops are not cleared.
- Simultaneous events:
  - ack and edge in CHEIO: ack wins, the edge is dropped, count = 00.
  - ack outside CHEIO: no effect.
  - en falling on the same cycle as an edge in CONTANDO: the edge is dropped, state PARADO.
- Reset mid-operation: takes effect at the next clk edge regardless of state; the partial count is lost.
- Outputs are registered; no combinational path from any input to any output.

Decomposition:
- Shared package:
  - state encoding constants PARADO/CONTANDO/CHEIO (2 bits);
  - BCD_MAX=9;
  - default LOTE.
- One natural sub-module, modulo_sincroniza_borda: synchroniser plus rising-edge detector, parameter SYNC_STAGES, outputs edge. It is reusable for the cap-sensor counter.
- The BCD decade increment stays inline.

Test Plan:
- Reset, then en=1, then 3 isolated sensor pulses (4 cycles high, 4 low):
  - unidade=3, dezena=0;
  - exactly 3 pulso_garrafa strobes, each 2 edges after the first high sample;
  - lote_completo=0.
- LOTE=12, 12 pulses:
  - after pulse 10, unidade=0, dezena=1;
  - after pulse 12, dezena=1, unidade=2 and lote_completo=1 on the same edge;
  - pulse 13 gives no strobe and no change.
- In CHEIO, ack asserted together with a detected edge:
  - count 00, state CONTANDO, no pulso_garrafa;
  - the next pulse gives unidade=1.
- Sensor held high for 50 cycles -> count +1 only.
- en=0 during 2 pulses -> count unchanged. en=1 afterwards -> next pulse increments.
- Count at 07, then clr coincident with an edge, and separately rst_n=0 mid-count:
  - clr: count 00, no strobe;
  - reset: all outputs 0, state PARADO, and a pulse with en=0 does not count.
